// File: rtl/i2c_write_sequencer.sv
// i2c_write_sequencer: walks a table of (device address, data) byte writes,
// launching each on an external byte-write engine and waiting for completion.
// Optional feature: define I2C_SEQ_RETRY_EN to retry a write that ends in an
// acknowledge error up to MAX_RETRIES extra times before failing.
module i2c_write_sequencer #(
  parameter int NUM_WRITES  = 3,
  parameter int TIMEOUT_CYC = 125000,
  parameter int MAX_RETRIES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    seq_start,
  input  logic [8*NUM_WRITES-1:0] seq_dev_adr,
  input  logic [8*NUM_WRITES-1:0] seq_reg_dat,
  input  logic                    i2c_wr_done,
  input  logic                    i2c_ack_err,
  output logic [7:0]              i2c_dev_adr,
  output logic [7:0]              i2c_reg_dat,
  output logic                    i2c_start_write,
  output logic                    sm_busy,
  output logic                    seq_done,
  output logic                    seq_error,
  output logic [3:0]              err_index
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  // Reject table sizes the 4-bit index cannot address.
  if (NUM_WRITES < 1 || NUM_WRITES > 16 || MAX_RETRIES < 0) begin : g_param_chk
    $error("i2c_write_sequencer: NUM_WRITES must be 1..16, MAX_RETRIES >= 0");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_REQ, S_WAIT, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t                         state_q, state_d;
  logic [NUM_WRITES-1:0][7:0]     snap_adr_q, snap_adr_d;
  logic [NUM_WRITES-1:0][7:0]     snap_dat_q, snap_dat_d;
  logic [3:0]                     idx_q, idx_d;
  logic [TMO_W-1:0]               tmo_q, tmo_d;
  logic [7:0]                     dev_adr_q, dev_adr_d;
  logic [7:0]                     reg_dat_q, reg_dat_d;
  logic                           start_q, start_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           err_q, err_d;
  logic [3:0]                     err_idx_q, err_idx_d;
  logic [7:0]                     cur_adr, cur_dat;

`ifdef I2C_SEQ_RETRY_EN
  localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  logic [RTY_W-1:0]               retry_q, retry_d;
`endif

  // Select the snapshot entry for the current index (compare-mux keeps the
  // 4-bit index from over-reaching a smaller table).
  always_comb begin
    cur_adr = '0;
    cur_dat = '0;
    for (int k = 0; k < NUM_WRITES; k++) begin
      if (idx_q == 4'(k)) begin
        cur_adr = snap_adr_q[k];
        cur_dat = snap_dat_q[k];
      end
    end
  end

  // Next-state and registered-output logic; outputs follow the state being entered.
  always_comb begin
    state_d    = state_q;
    snap_adr_d = snap_adr_q;
    snap_dat_d = snap_dat_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    dev_adr_d  = dev_adr_q;
    reg_dat_d  = reg_dat_q;
    err_d      = err_q;
    err_idx_d  = err_idx_q;
`ifdef I2C_SEQ_RETRY_EN
    retry_d    = retry_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (seq_start) begin
          snap_adr_d = seq_dev_adr;
          snap_dat_d = seq_reg_dat;
          idx_d      = '0;
          err_d      = 1'b0;
`ifdef I2C_SEQ_RETRY_EN
          retry_d    = '0;
`endif
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        dev_adr_d = cur_adr;
        reg_dat_d = cur_dat;
        state_d   = S_REQ;
      end
      S_REQ: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Completion beats timeout; expiry lands in the TIMEOUT_CYC-th WAIT cycle.
        if (i2c_wr_done) begin
          if (!i2c_ack_err) begin
`ifdef I2C_SEQ_RETRY_EN
            retry_d = '0;
`endif
            state_d = S_CHECK;
          end else begin
`ifdef I2C_SEQ_RETRY_EN
            if (retry_q < RTY_W'(MAX_RETRIES)) begin
              retry_d = retry_q + 1'b1;
              state_d = S_REQ;
            end else begin
              state_d = S_ERROR;
            end
`else
            state_d = S_ERROR;
`endif
          end
        end else if (tmo_q >= TMO_W'(TIMEOUT_CYC - 1)) begin
          state_d = S_ERROR;
        end else if (tmo_q != TMO_W'(TIMEOUT_CYC)) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (idx_q == 4'(NUM_WRITES - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_ERROR && state_q != S_ERROR) begin
      err_d     = 1'b1;
      err_idx_d = idx_q;
    end
    start_d = (state_d == S_REQ);
    done_d  = (state_d == S_DONE);
    busy_d  = (state_d == S_LOAD) || (state_d == S_REQ) ||
              (state_d == S_WAIT) || (state_d == S_CHECK);
  end

  // State, counter, snapshot and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      snap_adr_q <= '0;
      snap_dat_q <= '0;
      idx_q      <= '0;
      tmo_q      <= '0;
      dev_adr_q  <= '0;
      reg_dat_q  <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      snap_adr_q <= snap_adr_d;
      snap_dat_q <= snap_dat_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      dev_adr_q  <= dev_adr_d;
      reg_dat_q  <= reg_dat_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_idx_q  <= err_idx_d;
    end
  end

`ifdef I2C_SEQ_RETRY_EN
  // Retry counter for the write in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) retry_q <= '0;
    else       retry_q <= retry_d;
  end
`endif

  assign i2c_dev_adr     = dev_adr_q;
  assign i2c_reg_dat     = reg_dat_q;
  assign i2c_start_write = start_q;
  assign sm_busy         = busy_q;
  assign seq_done        = done_q;
  assign seq_error       = err_q;
  assign err_index       = err_idx_q;

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Scoreboard bench for i2c_write_sequencer: stimulus pushes expected write
// launches and sequence outcomes; a monitor pops and compares them.
module tb_i2c_write_sequencer;
  localparam int NW  = 3;
  localparam int TMO = 50;
  localparam int MR  = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            seq_start = 1'b0;
  logic [8*NW-1:0] seq_dev_adr = '0;
  logic [8*NW-1:0] seq_reg_dat = '0;
  logic            i2c_wr_done = 1'b0;
  logic            i2c_ack_err = 1'b0;
  logic [7:0]      i2c_dev_adr, i2c_reg_dat;
  logic            i2c_start_write, sm_busy, seq_done, seq_error;
  logic [3:0]      err_index;

  always #4 clk = ~clk;

  i2c_write_sequencer #(.NUM_WRITES(NW), .TIMEOUT_CYC(TMO), .MAX_RETRIES(MR)) dut (
    .clk(clk), .reset(reset), .seq_start(seq_start),
    .seq_dev_adr(seq_dev_adr), .seq_reg_dat(seq_reg_dat),
    .i2c_wr_done(i2c_wr_done), .i2c_ack_err(i2c_ack_err),
    .i2c_dev_adr(i2c_dev_adr), .i2c_reg_dat(i2c_reg_dat),
    .i2c_start_write(i2c_start_write), .sm_busy(sm_busy),
    .seq_done(seq_done), .seq_error(seq_error), .err_index(err_index)
  );

  typedef struct { logic [7:0] adr; logic [7:0] dat; } wr_t;
  typedef struct { bit err; logic [3:0] idx; int lat; } out_t;

  wr_t  exp_wr[$];
  out_t exp_out[$];
  int   rsp_dly[$];
  bit   rsp_ack[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_start = 0;

  logic [7:0] tbl_adr [NW] = '{8'hE8, 8'h70, 8'hE8};
  logic [7:0] tbl_dat [NW] = '{8'h04, 8'hA5, 8'h00};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event expected none", name);
  endtask

  task automatic set_table();
    for (int k = 0; k < NW; k++) begin
      seq_dev_adr[8*k +: 8] = tbl_adr[k];
      seq_reg_dat[8*k +: 8] = tbl_dat[k];
    end
  endtask

  task automatic push_wr(input int k);
    wr_t w;
    w.adr = tbl_adr[k];
    w.dat = tbl_dat[k];
    exp_wr.push_back(w);
  endtask

  task automatic push_rsp(input int d, input bit a);
    rsp_dly.push_back(d);
    rsp_ack.push_back(a);
  endtask

  task automatic push_out(input bit e, input int idx, input int lat);
    out_t o;
    o.err = e;
    o.idx = 4'(idx);
    o.lat = lat;
    exp_out.push_back(o);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    seq_start = 1'b1;
    @(negedge clk);
    seq_start = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_wr.size() != 0 || exp_out.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (8) @(negedge clk);
    checks++;
    if (exp_wr.size() != 0 || exp_out.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d writes %0d outcomes pending expected 0",
               name, exp_wr.size(), exp_out.size());
      exp_wr.delete();
      exp_out.delete();
    end
    rsp_dly.delete();
    rsp_ack.delete();
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_adr"},   i2c_dev_adr, 0);
    chk({name, "_dat"},   i2c_reg_dat, 0);
    chk({name, "_start"}, i2c_start_write, 0);
    chk({name, "_busy"},  sm_busy, 0);
    chk({name, "_done"},  seq_done, 0);
    chk({name, "_err"},   seq_error, 0);
    chk({name, "_eidx"},  err_index, 0);
  endtask

  // Monitor: compares each launch and each sequence outcome with the scoreboard.
  initial begin : mon
    logic err_prev;
    wr_t  w;
    out_t o;
    err_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        err_prev = 1'b0;
        continue;
      end
      if (i2c_start_write) begin
        last_start = cyc;
        chk("busy_at_start", sm_busy, 1);
        chk("err_clear_at_start", seq_error, 0);
        if (exp_wr.size() == 0) miss("extra_start");
        else begin
          w = exp_wr.pop_front();
          chk("wr_adr", i2c_dev_adr, w.adr);
          chk("wr_dat", i2c_reg_dat, w.dat);
        end
      end
      if (seq_done || (seq_error && !err_prev)) begin
        if (exp_out.size() == 0) miss("extra_outcome");
        else begin
          o = exp_out.pop_front();
          chk("outcome_err", seq_error, o.err);
          chk("outcome_done", seq_done, !o.err);
          if (o.err) chk("err_index", err_index, o.idx);
          else chk("busy_at_done", sm_busy, 0);
          if (o.lat >= 0) chk("err_latency", cyc - last_start, o.lat);
        end
      end
      err_prev = seq_error;
    end
  end

  // Byte-write engine model: answers each launch after a scripted delay.
  initial begin : rsp
    bit skip;
    int d;
    bit a;
    skip = 1'b0;
    forever begin
      if (!skip) @(negedge clk);
      skip = 1'b0;
      if (i2c_start_write && !reset) begin
        if (rsp_dly.size() == 0) miss("rsp_script");
        else begin
          d = rsp_dly.pop_front();
          a = rsp_ack.pop_front();
          if (d > 0) begin
            repeat (d) @(negedge clk);
            i2c_wr_done = 1'b1;
            i2c_ack_err = a;
            @(negedge clk);
            i2c_wr_done = 1'b0;
            i2c_ack_err = 1'b0;
            skip = 1'b1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    set_table();
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    // Nominal three-write sequence.
    for (int k = 0; k < NW; k++) begin push_wr(k); push_rsp(4, 0); end
    push_out(0, 0, -1);
    pulse_start();
    drain("basic");

    // Completion in the very cycle the timeout would expire.
    push_rsp(TMO, 0); push_rsp(4, 0); push_rsp(4, 0);
    for (int k = 0; k < NW; k++) push_wr(k);
    push_out(0, 0, -1);
    pulse_start();
    drain("tmo_edge");

    // No completion on write 0: error decided TMO cycles after launch.
    push_rsp(-1, 0);
    push_wr(0);
    push_out(1, 0, TMO + 1);
    pulse_start();
    drain("timeout");

`ifdef I2C_SEQ_RETRY_EN
    // Two ack errors on write 2 are absorbed by retries.
    push_rsp(4, 0); push_rsp(4, 0); push_rsp(4, 1); push_rsp(4, 1); push_rsp(4, 0);
    push_wr(0); push_wr(1); push_wr(2); push_wr(2); push_wr(2);
    push_out(0, 0, -1);
    pulse_start();
    drain("retry_ok");

    // A third ack error exhausts the retries.
    push_rsp(4, 0); push_rsp(4, 0); push_rsp(4, 1); push_rsp(4, 1); push_rsp(4, 1);
    push_wr(0); push_wr(1); push_wr(2); push_wr(2); push_wr(2);
    push_out(1, 2, -1);
    pulse_start();
    drain("retry_fail");
`else
    // Ack error on write 1 fails the sequence immediately.
    push_rsp(4, 0); push_rsp(4, 1);
    push_wr(0); push_wr(1);
    push_out(1, 1, -1);
    pulse_start();
    drain("ack_err");
`endif

    // Table change and a second start during write 1 have no effect.
    push_rsp(4, 0); push_rsp(20, 0); push_rsp(4, 0);
    for (int k = 0; k < NW; k++) push_wr(k);
    push_out(0, 0, -1);
    pulse_start();
    n = 0;
    while (exp_wr.size() > 1 && n < 200) begin @(negedge clk); n++; end
    seq_dev_adr = 24'h123456;
    seq_reg_dat = 24'hABCDEF;
    pulse_start();
    drain("snapshot");
    set_table();

    // Reset while waiting on write 1, then a clean full run.
    push_rsp(4, 0); push_rsp(-1, 0);
    push_wr(0); push_wr(1);
    pulse_start();
    n = 0;
    while (exp_wr.size() != 0 && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("busy_before_reset", sm_busy, 1);
    #1 reset = 1'b1;
    #1 chk_all_zero("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    drain("reset");
    for (int k = 0; k < NW; k++) begin push_wr(k); push_rsp(4, 0); end
    push_out(0, 0, -1);
    pulse_start();
    drain("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
